// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: state encodings, timing defaults and frame helpers
// used by both the host transmitter and the receiver.
package ps2_defs;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        START,
        SHIFT,
        ACK,
        WAIT_REL
    } ps2_tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_STOP
    } ps2_rx_state_t;

    // Defaults assume a 50 MHz system clock
    localparam int unsigned PS2_INHIBIT_CYCLES = 6000;
    localparam int unsigned PS2_TIMEOUT_CYCLES = 750000;
    localparam int unsigned PS2_FILTER_LEN     = 8;

    localparam logic [3:0] PS2_LAST_BIT_EDGE = 4'd9;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Brings one raw PS/2 line into the clk_i domain, rejects glitches shorter
// than FILTER_LEN samples and flags filtered 1->0 transitions.
module ps2_line_filter
    import ps2_defs::*;
#(
    parameter int unsigned FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic line_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync_q;
    logic             filt_q;
    logic             fall_q;
    logic [CNT_W-1:0] cnt_q;

    // Lines idle high, so everything resets to the released level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            fall_q <= 1'b0;
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                filt_q <= sync_q[1];
                fall_q <= filt_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign line_o = filt_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts
// out one command byte on device clock edges and checks the device ack.
module ps2_host_tx
    import ps2_defs::*;
#(
    parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_start_i,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       tx_err_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    localparam int unsigned TIMER_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                        INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t      state_q, state_n;
    logic [TIMER_W-1:0] timer_q, timer_n;
    logic [3:0]         edge_q, edge_n;
    logic [8:0]         frame_q, frame_n;
    logic               drive_q, drive_n;
    logic               done_q, done_n;
    logic               err_q, err_n;

    logic clk_filt, clk_fall;
    logic data_filt, data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .line_i (ps2_clk_i),
        .line_o (clk_filt),
        .fall_o (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .line_i (ps2_data_i),
        .line_o (data_filt),
        .fall_o (data_fall_unused)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            edge_q  <= '0;
            frame_q <= '0;
            drive_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
            edge_q  <= edge_n;
            frame_q <= frame_n;
            drive_q <= drive_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    // frame holds {parity, data}; drive is the level currently put on the data line
    always_comb begin
        state_n       = state_q;
        timer_n       = timer_q;
        edge_n        = edge_q;
        frame_n       = frame_q;
        drive_n       = drive_q;
        done_n        = 1'b0;
        err_n         = 1'b0;
        ps2_clk_oe_o  = 1'b0;
        ps2_data_oe_o = 1'b0;
        tx_busy_o     = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                timer_n = '0;
                if (tx_start_i && !done_q && !err_q) begin
                    frame_n = {odd_parity(tx_data_i), tx_data_i};
                    edge_n  = '0;
                    drive_n = 1'b0;
                    state_n = INHIBIT;
                end
            end

            INHIBIT: begin
                ps2_clk_oe_o = 1'b1;
                if (timer_q == INHIBIT_LAST) begin
                    timer_n = '0;
                    state_n = REQ;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end

            REQ: begin
                ps2_clk_oe_o  = 1'b1;
                ps2_data_oe_o = 1'b1;
                timer_n       = '0;
                drive_n       = 1'b0;
                state_n       = START;
            end

            START, SHIFT: begin
                ps2_data_oe_o = ~drive_q;
                if (clk_fall) begin
                    timer_n = '0;
                    edge_n  = edge_q + 4'd1;
                    if (state_q == START) begin
                        drive_n = frame_q[0];
                        state_n = SHIFT;
                    end else if (edge_q == PS2_LAST_BIT_EDGE) begin
                        drive_n = 1'b1;
                        state_n = ACK;
                    end else begin
                        drive_n = frame_q[edge_q];
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end

            ACK: begin
                if (clk_fall) begin
                    timer_n = '0;
                    edge_n  = edge_q + 4'd1;
                    if (!data_filt) begin
                        state_n = WAIT_REL;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end

            WAIT_REL: begin
                if (clk_filt && data_filt) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (clk_fall) begin
                    timer_n = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign tx_done_o = done_q;
    assign tx_err_o  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-collector bus and a
// behavioural PS/2 device that clocks the frame in and answers with an ack.
module tb_ps2_host_tx;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 400;
    localparam int FLEN    = 4;
    localparam int HALF    = 20;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_START  = 1;
    localparam int MODE_GLITCH = 2;
    localparam int MODE_RESET  = 3;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] tx_data_i;
    logic       tx_start_i;
    logic       tx_busy_o, tx_done_o, tx_err_o;
    logic       ps2_clk_i, ps2_data_i;
    logic       ps2_clk_oe_o, ps2_data_oe_o;
    logic       dev_clk, dev_data;

    int checks = 0;
    int errors = 0;

    assign ps2_clk_i  = ~ps2_clk_oe_o & dev_clk;
    assign ps2_data_i = ~ps2_data_oe_o & dev_data;

    always #5 clk_i = ~clk_i;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FILTER_LEN     (FLEN)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .tx_data_i     (tx_data_i),
        .tx_start_i    (tx_start_i),
        .tx_busy_o     (tx_busy_o),
        .tx_done_o     (tx_done_o),
        .tx_err_o      (tx_err_o),
        .ps2_clk_i     (ps2_clk_i),
        .ps2_data_i    (ps2_data_i),
        .ps2_clk_oe_o  (ps2_clk_oe_o),
        .ps2_data_oe_o (ps2_data_oe_o)
    );

    // Running tallies of bus activity and pulse-rule violations
    int   clk_oe_cycles    = 0;
    int   done_pulses      = 0;
    int   err_pulses       = 0;
    int   overlap_cycles   = 0;
    int   busy_after_pulse = 0;
    logic prev_pulse       = 1'b0;

    always @(negedge clk_i) begin
        if (ps2_clk_oe_o === 1'b1) clk_oe_cycles++;
        if (tx_done_o === 1'b1) done_pulses++;
        if (tx_err_o === 1'b1) err_pulses++;
        if (tx_done_o === 1'b1 && tx_err_o === 1'b1) overlap_cycles++;
        if (prev_pulse && tx_busy_o !== 1'b0) busy_after_pulse++;
        prev_pulse = (tx_done_o === 1'b1) || (tx_err_o === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Frame as the device sees it: start, data LSB first, odd parity, stop
    function automatic logic [10:0] expectedFrame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk_i);
        tx_data_i  = b;
        tx_start_i = 1'b1;
        @(negedge clk_i);
        tx_start_i = 1'b0;
    endtask

    task automatic deviceRun(input int ack_ok, input int mode, output logic [10:0] seen,
                             output int started, output int aborted);
        seen    = '1;
        started = 0;
        aborted = 0;
        for (int i = 0; i < 200 && started == 0; i++) begin
            @(negedge clk_i);
            if (ps2_clk_oe_o === 1'b0 && ps2_data_oe_o === 1'b1) started = 1;
        end
        if (started == 0) return;
        repeat (HALF) @(negedge clk_i);
        seen[0] = ps2_data_i;
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (mode == MODE_RESET && k == 5) begin
                repeat (10) @(negedge clk_i);
                #2 rst_i = 1'b1;
                #1;
                checkOutput("reset_mid_clk_oe", 32'(ps2_clk_oe_o), 32'd0);
                checkOutput("reset_mid_data_oe", 32'(ps2_data_oe_o), 32'd0);
                checkOutput("reset_mid_busy", 32'(tx_busy_o), 32'd0);
                repeat (5) @(negedge clk_i);
                dev_clk = 1'b1;
                rst_i   = 1'b0;
                aborted = 1;
                return;
            end
            if (mode == MODE_START && k == 3) begin
                repeat (10) @(negedge clk_i);
                tx_data_i  = 8'hAA;
                tx_start_i = 1'b1;
                @(negedge clk_i);
                tx_start_i = 1'b0;
                repeat (HALF - 11) @(negedge clk_i);
            end else begin
                repeat (HALF) @(negedge clk_i);
            end
            dev_clk = 1'b1;
            if (mode == MODE_GLITCH && k == 4) begin
                repeat (8) @(negedge clk_i);
                dev_clk = 1'b0;
                repeat (2) @(negedge clk_i);
                dev_clk = 1'b1;
                repeat (HALF - 10) @(negedge clk_i);
            end else begin
                repeat (HALF) @(negedge clk_i);
            end
            if (k <= 10) seen[k] = ps2_data_i;
            if (k == 10) begin
                if (ack_ok != 0) dev_data = 1'b0;
                repeat (10) @(negedge clk_i);
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic runTransfer(input string tag, input logic [7:0] b, input int ack_ok,
                               input int mode, input logic [7:0] expect_byte);
        logic [10:0] seen;
        int started, aborted;
        int oe0, d0, e0;
        oe0 = clk_oe_cycles;
        d0  = done_pulses;
        e0  = err_pulses;
        applyStimulus(b);
        deviceRun(ack_ok, mode, seen, started, aborted);
        checkOutput({tag, "_started"}, 32'(started), 32'd1);
        repeat (30) @(negedge clk_i);
        if (aborted != 0) begin
            checkOutput({tag, "_abort_done"}, 32'(done_pulses - d0), 32'd0);
            checkOutput({tag, "_abort_err"}, 32'(err_pulses - e0), 32'd0);
            return;
        end
        checkOutput({tag, "_frame"}, 32'(seen), 32'(expectedFrame(expect_byte)));
        checkOutput({tag, "_done_pulses"}, 32'(done_pulses - d0), (ack_ok != 0) ? 32'd1 : 32'd0);
        checkOutput({tag, "_err_pulses"}, 32'(err_pulses - e0), (ack_ok != 0) ? 32'd0 : 32'd1);
        checkOutput({tag, "_clk_oe_cycles"}, 32'(clk_oe_cycles - oe0), 32'(INHIBIT + 1));
        checkOutput({tag, "_clk_oe_idle"}, 32'(ps2_clk_oe_o), 32'd0);
        checkOutput({tag, "_data_oe_idle"}, 32'(ps2_data_oe_o), 32'd0);
        checkOutput({tag, "_busy_idle"}, 32'(tx_busy_o), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        int found, n, d0;

        rst_i      = 1'b1;
        tx_start_i = 1'b0;
        tx_data_i  = 8'h00;
        dev_clk    = 1'b1;
        dev_data   = 1'b1;
        repeat (3) @(negedge clk_i);
        checkOutput("reset_busy", 32'(tx_busy_o), 32'd0);
        checkOutput("reset_done", 32'(tx_done_o), 32'd0);
        checkOutput("reset_err", 32'(tx_err_o), 32'd0);
        checkOutput("reset_clk_oe", 32'(ps2_clk_oe_o), 32'd0);
        checkOutput("reset_data_oe", 32'(ps2_data_oe_o), 32'd0);
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);

        $display("[TB] send 0xED with ack");
        runTransfer("ed_ack", 8'hED, 1, MODE_NORMAL, 8'hED);

        $display("[TB] send 0x07 without ack");
        runTransfer("07_nack", 8'h07, 0, MODE_NORMAL, 8'h07);

        $display("[TB] send 0x55 to a silent device");
        d0 = done_pulses;
        applyStimulus(8'h55);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk_i);
            if (ps2_clk_oe_o === 1'b0 && ps2_data_oe_o === 1'b1) found = 1;
        end
        checkOutput("timeout_start_seen", 32'(found), 32'd1);
        n = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_i);
            n++;
            if (tx_err_o === 1'b1) break;
        end
        checkOutput("timeout_latency", 32'(n), 32'(TIMEOUT));
        checkOutput("timeout_clk_oe", 32'(ps2_clk_oe_o), 32'd0);
        checkOutput("timeout_data_oe", 32'(ps2_data_oe_o), 32'd0);
        checkOutput("timeout_no_done", 32'(done_pulses - d0), 32'd0);
        repeat (10) @(negedge clk_i);

        $display("[TB] send 0x55 with a start request at edge 3");
        runTransfer("start_ignored", 8'h55, 1, MODE_START, 8'h55);

        $display("[TB] send 0x3C with a clock glitch");
        runTransfer("glitch", 8'h3C, 1, MODE_GLITCH, 8'h3C);

        $display("[TB] reset at edge 5, then send 0xF4");
        runTransfer("reset_abort", 8'h99, 1, MODE_RESET, 8'h99);
        runTransfer("after_reset", 8'hF4, 1, MODE_NORMAL, 8'hF4);

        for (int r = 0; r < 4; r++) begin
            rb = 8'($urandom_range(0, 255));
            $display("[TB] random byte 0x%02h", rb);
            runTransfer("random", rb, 1, MODE_NORMAL, rb);
        end

        checkOutput("done_err_overlap", 32'(overlap_cycles), 32'd0);
        checkOutput("busy_after_pulse", 32'(busy_after_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
